// File: rtl/key_pkg.sv
// Shared types, default timing constants and a counter-width helper for the
// pushbutton conditioner.
package key_pkg;

   typedef enum logic {
      HOLD,
      RUN
   } seq_state_e;

   localparam int DEFAULT_DEBOUNCE      = 120000;
   localparam int DEFAULT_POR           = 16;
   localparam int DEFAULT_REPEAT_DELAY  = 12000000;
   localparam int DEFAULT_REPEAT_PERIOD = 2400000;

   // Bits needed to count 0..cycles-1, never less than one bit.
   function automatic int cnt_width(input int cycles);
      int w;
      w = 1;
      while ((1 << w) < cycles) w++;
      return w;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: two-flop synchroniser, debounce counter, press/release
// pulses and, when KEY_REPEAT_EN is defined, auto-repeat of the press pulse.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
   parameter bit REPEAT_ALLOW    = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic key_down,
   output logic key_press,
   output logic key_release,
   output logic down_next
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             down_q, down_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             rpt_pulse;

   // A differing input must survive DEBOUNCE_CYCLES samples in a row; any
   // sample matching the stable value restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      down_d    = ~stable_d;
      press_d   = (stable_q & ~stable_d) | rpt_pulse;
      release_d = ~stable_q & stable_d;
   end

`ifdef KEY_REPEAT_EN
   localparam int RPT_W = cnt_width(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [RPT_W-1:0] rpt_q, rpt_d;

   // Reloading to DELAY-PERIOD makes later pulses land every REPEAT_PERIOD.
   always_comb begin
      rpt_d     = '0;
      rpt_pulse = 1'b0;
      if (REPEAT_ALLOW && !stable_q && !stable_d) begin
         if (rpt_q == RPT_LAST) begin
            rpt_pulse = 1'b1;
            rpt_d     = RPT_RELOAD;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`else
   assign rpt_pulse = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b1;
         cnt_q     <= '0;
         down_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= key_n;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         down_q    <= down_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign key_down    = down_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign down_next   = down_d;

endmodule

// File: rtl/key_conditioner.sv
// Debounced front-end for NUM_KEYS active-low pushbuttons plus a stretched system
// reset from reset_n and key RST_KEY. Define KEY_REPEAT_EN for press auto-repeat.
module key_conditioner
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
   parameter int RST_KEY         = 0,
   parameter int POR_CYCLES      = DEFAULT_POR,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_down,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                sys_reset_n
);

   localparam int POR_W = cnt_width(POR_CYCLES);
   localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

   logic [NUM_KEYS-1:0] down_next;
   logic                rst_key_active;
   logic                rst_key_rise;
   seq_state_e          state_q;
   logic [POR_W-1:0]    por_q;
   logic                sys_reset_n_q;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .REPEAT_ALLOW   (i != RST_KEY)
      ) u_debounce (
         .clk        (clk),
         .reset_n    (reset_n),
         .key_n      (key_n[i]),
         .key_down   (key_down[i]),
         .key_press  (key_press[i]),
         .key_release(key_release[i]),
         .down_next  (down_next[i])
      );
   end

   // Using the next debounced level lets sys_reset_n drop in the same cycle the
   // reset key's key_down rises; the stretch counts from the cycle it falls.
   if (RST_KEY < NUM_KEYS) begin : g_rst_key
      assign rst_key_active = down_next[RST_KEY] | key_down[RST_KEY];
      assign rst_key_rise   = down_next[RST_KEY];
   end else begin : g_no_rst_key
      assign rst_key_active = 1'b0;
      assign rst_key_rise   = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= HOLD;
         por_q         <= '0;
         sys_reset_n_q <= 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               if (rst_key_active) begin
                  por_q <= '0;
               end else if (por_q == POR_LAST) begin
                  state_q       <= RUN;
                  por_q         <= '0;
                  sys_reset_n_q <= 1'b1;
               end else begin
                  por_q <= por_q + 1'b1;
               end
            end
            RUN: begin
               if (rst_key_rise) begin
                  state_q       <= HOLD;
                  por_q         <= '0;
                  sys_reset_n_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign sys_reset_n = sys_reset_n_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner, compared each cycle against
// a window-based behavioural model of debounce, repeat and reset stretching.
module tb_key_conditioner;

   localparam int NK     = 4;
   localparam int DEB    = 8;
   localparam int POR    = 4;
   localparam int RSTK   = 0;
   localparam int RDELAY = 20;
   localparam int RPER   = 6;

   logic          clk;
   logic          reset_n;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_down;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic          sys_reset_n;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   key_conditioner #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_CYCLES(DEB),
      .RST_KEY        (RSTK),
      .POR_CYCLES     (POR),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_n      (key_n),
      .key_down   (key_down),
      .key_press  (key_press),
      .key_release(key_release),
      .sys_reset_n(sys_reset_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a key's accepted level flips when the last DEB samples,
   // seen two edges late through the synchroniser, all disagree with it.
   logic          hist [NK][DEB+2];
   logic [NK-1:0] m_stable;
   logic [NK-1:0] prev_stable;
   int            held [NK];
   int            quiet;
   logic [NK-1:0] exp_down, exp_press, exp_release;
   logic          exp_sys;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NK; k++) begin
            for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1'b1;
            held[k] = 0;
         end
         m_stable    = '1;
         quiet       = 0;
         exp_down    = '0;
         exp_press   = '0;
         exp_release = '0;
         exp_sys     = 1'b0;
      end else begin
         prev_stable = m_stable;
         for (int k = 0; k < NK; k++) begin
            bit all_differ;
            for (int j = 0; j < DEB + 1; j++) hist[k][j] = hist[k][j+1];
            hist[k][DEB+1] = key_n[k];
            all_differ = 1'b1;
            for (int j = 0; j < DEB; j++)
               if (hist[k][j] == m_stable[k]) all_differ = 1'b0;
            if (all_differ) m_stable[k] = ~m_stable[k];
         end
         exp_down    = ~m_stable;
         exp_press   = prev_stable & ~m_stable;
         exp_release = ~prev_stable & m_stable;
`ifdef KEY_REPEAT_EN
         for (int k = 0; k < NK; k++) begin
            if (!prev_stable[k] && !m_stable[k]) begin
               held[k]++;
               if (k != RSTK && (held[k] == RDELAY ||
                   (held[k] > RDELAY && (held[k] - RDELAY) % RPER == 0)))
                  exp_press[k] = 1'b1;
            end else begin
               held[k] = 0;
            end
         end
`endif
         if (!prev_stable[RSTK] || !m_stable[RSTK]) quiet = 0;
         else if (quiet < POR) quiet++;
         exp_sys = (quiet >= POR);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NK-1:0] keys);
      @(negedge clk);
      #2;
      key_n = keys;
   endtask

   // Counts rising edges until the selected output bit reaches val; -1 on timeout.
   task automatic waitFor(input int sel, input int idx, input logic val,
                          output int edges);
      logic s;
      edges = -1;
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk);
         #1;
         case (sel)
            0:       s = key_down[idx];
            1:       s = key_press[idx];
            2:       s = key_release[idx];
            default: s = sys_reset_n;
         endcase
         if (s === val) begin
            edges = n;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("cyc_key_down", 32'(key_down), 32'(exp_down));
         checkOutput("cyc_key_press", 32'(key_press), 32'(exp_press));
         checkOutput("cyc_key_release", 32'(key_release), 32'(exp_release));
         checkOutput("cyc_sys_reset_n", 32'(sys_reset_n), 32'(exp_sys));
      end
   end

   initial begin
      int n;
      int pulses;
      int sys_edge;
      int press_edge;
      logic [NK-1:0] rnd;

      reset_n = 1'b0;
      key_n   = '1;
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      checkOutput("reset_key_down", 32'(key_down), 32'd0);
      checkOutput("reset_sys_reset_n", 32'(sys_reset_n), 32'd0);

      // Power-up stretch
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      waitFor(3, 0, 1'b1, n);
      checkOutput("por_edges", n, 4);

      // Clean press and release on key 2
      applyStimulus(4'b1011);
      waitFor(1, 2, 1'b1, n);
      checkOutput("press2_latency", n, 10);
      checkOutput("press2_level", 32'(key_down[2]), 32'd1);
      repeat (10) applyStimulus(4'b1011);
      applyStimulus(4'b1111);
      waitFor(2, 2, 1'b1, n);
      checkOutput("release2_latency", n, 10);

      // Short glitch on key 1 must be ignored
      repeat (5) applyStimulus(4'b1101);
      applyStimulus(4'b1111);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (key_press[1] || key_down[1]) pulses++;
      end
      checkOutput("glitch1_quiet", pulses, 0);

      // Bounce 0/1/0 then steady low
      repeat (3) applyStimulus(4'b1101);
      repeat (3) applyStimulus(4'b1111);
      applyStimulus(4'b1101);
      waitFor(1, 1, 1'b1, n);
      checkOutput("bounce1_latency", n, 10);
      applyStimulus(4'b1111);
      waitFor(2, 1, 1'b1, n);
      checkOutput("release1_latency", n, 10);

      // Reset key while running
      applyStimulus(4'b1110);
      waitFor(0, 0, 1'b1, n);
      checkOutput("rstkey_latency", n, 10);
      checkOutput("rstkey_sys_low", 32'(sys_reset_n), 32'd0);
      checkOutput("rstkey_press", 32'(key_press[0]), 32'd1);
      repeat (5) applyStimulus(4'b1110);
      applyStimulus(4'b1111);
      waitFor(0, 0, 1'b0, n);
      checkOutput("rstkey_release_latency", n, 10);
      waitFor(3, 0, 1'b1, n);
      checkOutput("rstkey_stretch", n, 4);

      // Asynchronous reset in the middle of a key 3 debounce
      applyStimulus(4'b0111);
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_key_down", 32'(key_down), 32'd0);
      checkOutput("async_key_press", 32'(key_press), 32'd0);
      checkOutput("async_key_release", 32'(key_release), 32'd0);
      checkOutput("async_sys_reset_n", 32'(sys_reset_n), 32'd0);
      repeat (3) @(negedge clk);
      #2;
      reset_n = 1'b1;
      sys_edge   = -1;
      press_edge = -1;
      for (int e = 1; e <= 16; e++) begin
         @(posedge clk);
         #1;
         if (sys_edge < 0 && sys_reset_n === 1'b1) sys_edge = e;
         if (press_edge < 0 && key_press[3] === 1'b1) press_edge = e;
      end
      checkOutput("after_reset_sys_edge", sys_edge, 4);
      checkOutput("after_reset_press3_edge", press_edge, 10);
      applyStimulus(4'b1111);
      repeat (14) applyStimulus(4'b1111);

      // Long hold on key 2: repeats only with the optional feature
      applyStimulus(4'b1011);
      waitFor(1, 2, 1'b1, n);
      checkOutput("hold2_latency", n, 10);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (key_press[2]) pulses++;
      end
`ifdef KEY_REPEAT_EN
      checkOutput("hold2_repeats", pulses, 6);
`else
      checkOutput("hold2_repeats", pulses, 0);
`endif
      applyStimulus(4'b1111);
      repeat (30) applyStimulus(4'b1111);

      // Random key activity, with one asynchronous reset part way through
      for (int it = 0; it < 400; it++) begin
         rnd = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) rnd[RSTK] = 1'b1;
         applyStimulus(rnd);
         repeat ($urandom_range(0, 11)) applyStimulus(rnd);
         if (it == 200) begin
            @(negedge clk);
            #2;
            reset_n = 1'b0;
            repeat (2) @(negedge clk);
            #2;
            reset_n = 1'b1;
         end
      end
      repeat (40) applyStimulus(4'b1111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
